button_conditioner: RTL and testbench

- Front-end stage for the dynamic LED lighting path.
- Synchronises the raw push-button pin, debounces it, and produces a clean level `button` that feeds the colour-cycling stage directly downstream.
- Also provides single-cycle press/release pulses and a long-press indication for later UI features.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchroniser, debounce FSM, press/release pulses, long-press level.
// Optional auto-repeat of press_pulse while held long is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned REPEAT_CYCLES   = 50,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button,
    output logic press_pulse,
    output logic release_pulse,
    output logic held_long
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Out-of-range settings would make the terminal compares unreachable.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > CNT_MAX ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > CNT_MAX) begin : g_bad_params
        $error("button_conditioner: parameter out of legal range");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t           state;
    logic             s1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= button_raw;
            s  <= s1;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            button        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            held_long     <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        button      <= 1'b1;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Hold (and repeat) progress only advances while the input still reads pressed.
                    if (!s) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end else begin
                        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) held_long <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        if (held_long) begin
                            if (rep_cnt == REP_LAST) begin
                                press_pulse <= 1'b1;
                                rep_cnt     <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                RELEASE_CHK: begin
                    if (s) begin
                        state <= PRESSED;
                    end else if (cnt == DEB_LAST) begin
                        state         <= IDLE;
                        button        <= 1'b0;
                        held_long     <= 1'b0;
                        release_pulse <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        rep_cnt       <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
// Expectations follow the edge-numbered timeline; auto-repeat pulses are expected only when BUTTON_AUTO_REPEAT_EN is defined.
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned H = 20;
    localparam int unsigned R = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic button_raw;
    logic button;
    logic press_pulse;
    logic release_pulse;
    logic held_long;

    logic [3:0] sb[$];
    int unsigned tests  = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_raw   (button_raw),
        .button       (button),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .held_long    (held_long)
    );

    function automatic logic [3:0] pack(bit b, bit p, bit r, bit h);
        return {b, p, r, h};
    endfunction

    task automatic test_reset();
        logic [3:0] got, want;
        rst = 1'b0;
        button_raw = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(pack(0, 0, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, got, want);
            end
        end
        @(negedge clk) rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            button_raw = 1'b0;
            sb.push_back(pack(0, 0, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    // Raw drops low and stays low; release is accepted on edge D+3.
    task automatic release_phase(string name, bit held_before, bit press_k1);
        logic [3:0] got, want;
        for (int k = 1; k <= 9; k++) begin
            button_raw = 1'b0;
            sb.push_back(pack(k < 7, press_k1 && k == 1, k == 7, held_before && k < 7));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL %s_release k=%0d got=%b want=%b", name, k, got, want);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] got, want;
        for (int k = 1; k <= 10; k++) begin
            button_raw = 1'b1;
            sb.push_back(pack(k >= 7, k == 7, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, got, want);
            end
        end
        release_phase("clean", 1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        logic [3:0] got, want;
        logic [4:0] pat;
        pat = 5'b10110;
        for (int k = 1; k <= 15; k++) begin
            button_raw = (k <= 5) ? pat[5-k] : 1'b0;
            sb.push_back(pack(0, 0, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_long_press();
        logic [3:0] got, want;
        for (int k = 1; k <= 40; k++) begin
            button_raw = 1'b1;
            sb.push_back(pack(k >= 7, k == 7 || (REP && k == 35), 0, k >= 27));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL long_press k=%0d got=%b want=%b", k, got, want);
            end
        end
        release_phase("long", 1'b1, 1'b0);
    endtask

    task automatic test_release_bounce();
        logic [3:0] got, want;
        for (int k = 1; k <= 42; k++) begin
            button_raw = (k <= 30 || k >= 33);
            sb.push_back(pack(k >= 7, k == 7 || (REP && k == 38), 0, k >= 27));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL release_bounce k=%0d got=%b want=%b", k, got, want);
            end
        end
        release_phase("rbounce", 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [3:0] got, want;
        for (int k = 1; k <= 4; k++) begin
            button_raw = 1'b1;
            sb.push_back(pack(0, 0, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL areset_chk k=%0d got=%b want=%b", k, got, want);
            end
        end
        #2 rst = 1'b0;
        sb.push_back(pack(0, 0, 0, 0));
        #1;
        got = {button, press_pulse, release_pulse, held_long};
        want = sb.pop_front();
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL areset_mid_chk got=%b want=%b", got, want);
        end
        @(negedge clk) rst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            sb.push_back(pack(k >= 7, k == 7, 0, k >= 27));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL areset_repress k=%0d got=%b want=%b", k, got, want);
            end
        end
        #2 rst = 1'b0;
        sb.push_back(pack(0, 0, 0, 0));
        #1;
        got = {button, press_pulse, release_pulse, held_long};
        want = sb.pop_front();
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL areset_mid_held got=%b want=%b", got, want);
        end
        @(negedge clk) rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            sb.push_back(pack(k >= 7, k == 7, 0, 0));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL areset_fresh k=%0d got=%b want=%b", k, got, want);
            end
        end
        release_phase("areset", 1'b0, 1'b0);
    endtask

    task automatic test_auto_repeat();
        logic [3:0] got, want;
        for (int k = 1; k <= 50; k++) begin
            button_raw = 1'b1;
            sb.push_back(pack(k >= 7, k == 7 || (REP && (k == 35 || k == 43)), 0, k >= 27));
            @(posedge clk); #1;
            got = {button, press_pulse, release_pulse, held_long};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL auto_repeat k=%0d got=%b want=%b", k, got, want);
            end
        end
        release_phase("repeat", 1'b1, REP);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_bounce();
        test_async_reset();
        test_auto_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
